// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared constants for the bit-serial adder: state encoding
//                and default operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bit
//  Description : One-bit combinational full adder built from two half-adder
//                stages whose carries are ORed together.
//  Ports       : x, y   - addend bits
//                cin    - carry in
//                s      - sum bit
//                cout   - carry out
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    // First half adder: x + y
    assign ha1_sum   = x ^ y;
    assign ha1_carry = x & y;

    // Second half adder: partial sum + carry in
    assign s         = ha1_sum ^ cin;
    assign ha2_carry = ha1_sum & cin;

    // At most one of the two stage carries can be set
    assign cout      = ha1_carry | ha2_carry;

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. Operands are captured on start, added LSB
//                first one bit per clock through a single full adder and a
//                carry flip-flop, and the result is published with a one
//                cycle done pulse. Result outputs hold until the next run
//                completes.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                start     - begin an addition (honoured in IDLE only)
//                a, b      - operands, captured on the accepting edge
//                busy      - high while bits are being added (SHIFT)
//                done      - one-cycle pulse, sum/carry_out valid
//                sum       - (a+b) mod 2^WIDTH
//                carry_out - bit WIDTH of a+b
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] res_shifted;

    full_adder_bit u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_sum),
        .cout (fa_carry)
    );

    assign last_bit    = (cnt_q == LAST_BIT);
    // Sum bits enter at the MSB and move right, so after WIDTH shifts the
    // first (LSB) sum bit sits at position 0.
    assign res_shifted = {fa_sum, res_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shifted;
                carry_d = fa_carry;
                cnt_d   = cnt_q + 1'b1;
                // Publish the finished result on the final shift edge so
                // it is already valid in the DONE cycle.
                if (last_bit) begin
                    sum_d  = res_shifted;
                    cout_d = fa_carry;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule : serial_adder
`default_nettype wire
